// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 initiator.
package apb_pkg;

   // Bridge FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DECERR = 2'd3
   } apb_state_e;

   // Read data returned on any error completion.
   localparam logic [31:0] APB_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slot decoder: upper CPU address bits -> {hit, slot index}.
// Only the bits above the slot offset are passed in; the offset never
// affects the decode.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
   parameter int          SLOT_BITS  = 12,
   parameter int          SEL_BITS   = $clog2(NUM_SLAVES)
) (
   input  logic [31-SLOT_BITS:0] addr_hi_i,
   output logic                  hit_o,
   output logic [SEL_BITS-1:0]   idx_o
);

   logic        base_match_s;
   logic [31:0] idx_ext_s;

   assign idx_o        = addr_hi_i[SEL_BITS-1:0];
   assign idx_ext_s    = 32'(idx_o);
   assign base_match_s = (addr_hi_i[31-SLOT_BITS:SEL_BITS] == ADDR_BASE[31:SLOT_BITS+SEL_BITS]);
   // Non-power-of-two slot counts leave holes at the top of the window.
   assign hit_o        = base_match_s && (idx_ext_s < 32'(NUM_SLAVES));

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: latches one CPU request, runs SETUP/ACCESS against the
// decoded slot and returns a single-cycle ready pulse with data or error.
module apb_master
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES     = 4,
   parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
   parameter int          SLOT_BITS      = 12,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    transfer,
   input  logic [31:0]             addr,
   input  logic [31:0]             wdata,
   input  logic                    write,
   output logic                    ready,
   output logic [31:0]             rdata,
   output logic                    err,
   output logic [31:0]             PADDR,
   output logic [31:0]             PWDATA,
   output logic                    PWRITE,
   output logic [NUM_SLAVES-1:0]   PSEL,
   output logic                    PENABLE,
   input  logic [32*NUM_SLAVES-1:0] PRDATA_s,
   input  logic [NUM_SLAVES-1:0]   PREADY_s
);

   localparam int                 SEL_BITS = $clog2(NUM_SLAVES);
   localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_SLAVES-1:0] SEL_ONE = {{(NUM_SLAVES-1){1'b0}}, 1'b1};

   apb_state_e            state_q, state_d;
   logic [31:0]           paddr_q, paddr_d;
   logic [31:0]           pwdata_q, pwdata_d;
   logic                  pwrite_q, pwrite_d;
   logic [NUM_SLAVES-1:0] psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  dec_hit_s;
   logic [SEL_BITS-1:0]   dec_idx_s;
   logic                  sel_ready_s;
   logic [31:0]           sel_rdata_s;
   logic                  timeout_s;

   apb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_BASE  (ADDR_BASE),
      .SLOT_BITS  (SLOT_BITS),
      .SEL_BITS   (SEL_BITS)
   ) u_dec (
      .addr_hi_i (addr[31:SLOT_BITS]),
      .hit_o     (dec_hit_s),
      .idx_o     (dec_idx_s)
   );

   // psel_q is one-hot (or zero), so masking selects the addressed slave only.
   assign sel_ready_s = |(PREADY_s & psel_q);
   assign timeout_s   = (cnt_q == CNT_LAST);

   // AND-OR mux of the selected slave's read data.
   always_comb begin
      sel_rdata_s = 32'h0000_0000;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_rdata_s = sel_rdata_s | (PRDATA_s[32*i +: 32] & {32{psel_q[i]}});
      end
   end

   // Next-state logic for the FSM, request registers, select lines and timeout counter.
   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               paddr_d  = addr;
               pwdata_d = wdata;
               pwrite_d = write;
               if (dec_hit_s) begin
                  state_d = SETUP;
                  psel_d  = SEL_ONE << dec_idx_s;
               end else begin
                  state_d = DECERR;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
         end
         ACCESS: begin
            if (sel_ready_s || timeout_s) begin
               state_d   = IDLE;
               psel_d    = {NUM_SLAVES{1'b0}};
               penable_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DECERR: begin
            state_d   = IDLE;
            psel_d    = {NUM_SLAVES{1'b0}};
            penable_d = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            psel_d    = {NUM_SLAVES{1'b0}};
            penable_d = 1'b0;
         end
      endcase
   end

   // CPU response; suppressed while reset is asserted so an aborted request never completes.
   always_comb begin
      ready = 1'b0;
      err   = 1'b0;
      rdata = APB_ERR_RDATA;
      if (PRESET) begin
         ready = 1'b0;
      end else begin
         case (state_q)
            ACCESS: begin
               if (sel_ready_s) begin
                  ready = 1'b1;
                  err   = 1'b0;
                  rdata = pwrite_q ? APB_ERR_RDATA : sel_rdata_s;
               end else if (timeout_s) begin
                  ready = 1'b1;
                  err   = 1'b1;
               end else begin
                  ready = 1'b0;
               end
            end
            DECERR: begin
               ready = 1'b1;
               err   = 1'b1;
            end
            default: begin
               ready = 1'b0;
            end
         endcase
      end
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= IDLE;
         paddr_q   <= 32'h0000_0000;
         pwdata_q  <= 32'h0000_0000;
         pwrite_q  <= 1'b0;
         psel_q    <= {NUM_SLAVES{1'b0}};
         penable_q <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         cnt_q     <= cnt_d;
      end
   end

   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;
   assign PWRITE  = pwrite_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers checked against an address-window / latency reference model.
module tb_apb_master;

   localparam int          NS   = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          TO   = 4;

   logic          PCLK;
   logic          PRESET;
   logic          transfer;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic          write;
   logic          ready;
   logic [31:0]   rdata;
   logic          err;
   logic [31:0]   PADDR;
   logic [31:0]   PWDATA;
   logic          PWRITE;
   logic [NS-1:0] PSEL;
   logic          PENABLE;
   logic [32*NS-1:0] PRDATA_s;
   logic [NS-1:0] PREADY_s;

   int total = 0;
   int bad   = 0;

   // observations of the most recent transfer
   int          obs_k;
   logic        obs_err, obs_pwrite, obs_pen1, obs_penc, obs_pen_after;
   logic        obs_ready_after, obs_err_after;
   logic [31:0] obs_rdata, obs_paddr, obs_pwdata, obs_rdata_after;
   logic [3:0]  obs_psel1, obs_pselc, obs_psel_after;

   // model outputs
   int          ek;
   logic        eerr;
   logic [31:0] erd;
   logic [3:0]  epsel;

   apb_master #(
      .NUM_SLAVES     (NS),
      .ADDR_BASE      (BASE),
      .SLOT_BITS      (12),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .addr     (addr),
      .wdata    (wdata),
      .write    (write),
      .ready    (ready),
      .rdata    (rdata),
      .err      (err),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA_s (PRDATA_s),
      .PREADY_s (PREADY_s)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Slot index of an address inside the APB window, or -1 when outside.
   function automatic int slot_of(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      if (off >= 64'sd0 && off < longint'(NS) * 64'sd4096) return int'(off / 64'sd4096);
      else return -1;
   endfunction

   // Expected completion cycle (relative to the sampling edge), err, rdata and PSEL.
   function automatic void model(input logic [31:0] a, input logic wr, input int w,
                                 input logic [31:0] sd);
      int s;
      s = slot_of(a);
      epsel = (s >= 0) ? (4'b0001 << s) : 4'b0000;
      if (s < 0) begin ek = 1; eerr = 1'b1; erd = 32'h0; end
      else if (w < TO) begin ek = 2 + w; eerr = 1'b0; erd = wr ? 32'h0 : sd; end
      else begin ek = 1 + TO; eerr = 1'b1; erd = 32'h0; end
   endfunction

   // Issue one request; the addressed slave raises PREADY after w ACCESS cycles.
   task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                           input int w, input logic [31:0] sd, input logic keep,
                           input logic [3:0] noise_or);
      int s;
      logic [3:0] mask;
      s = slot_of(a);
      mask = (s >= 0) ? (4'b0001 << s) : 4'b0000;
      transfer = 1'b1; addr = a; wdata = wd; write = wr; PREADY_s = 4'b0000;
      @(posedge PCLK); #1;
      transfer = keep; addr = $urandom; wdata = $urandom; write = 1'($urandom);
      obs_k = -1;
      for (int k = 1; k <= 12; k++) begin
         for (int i = 0; i < NS; i++) PRDATA_s[32*i +: 32] = $urandom;
         PREADY_s = (4'($urandom) | noise_or) & ~mask;
         if (s >= 0) begin
            PRDATA_s[32*s +: 32] = sd;
            if (k >= 2 && (k - 2) >= w) PREADY_s[s] = 1'b1;
         end
         @(negedge PCLK);
         if (k == 1) begin obs_psel1 = PSEL; obs_pen1 = PENABLE; end
         if (ready === 1'b1) begin
            obs_k = k; obs_err = err; obs_rdata = rdata;
            obs_paddr = PADDR; obs_pwdata = PWDATA; obs_pwrite = PWRITE;
            obs_pselc = PSEL; obs_penc = PENABLE;
            break;
         end
         @(posedge PCLK); #1;
      end
      @(posedge PCLK); #1;
      transfer = 1'b0; PREADY_s = 4'b0000;
      @(negedge PCLK);
      obs_psel_after = PSEL; obs_pen_after = PENABLE;
      obs_ready_after = ready; obs_err_after = err; obs_rdata_after = rdata;
   endtask

   task automatic test_reset();
      PRESET = 1'b1; transfer = 1'b0; addr = 32'h0; wdata = 32'h0; write = 1'b0;
      PRDATA_s = '0; PREADY_s = 4'b0000;
      @(posedge PCLK); @(negedge PCLK);
      total++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL reset_resp got ready=%b err=%b rdata=%h want 0/0/0", ready, err, rdata); end
      total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin bad++; $display("FAIL reset_sel got PSEL=%b PENABLE=%b want 0000/0", PSEL, PENABLE); end
      total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin bad++; $display("FAIL reset_req got %h %h %b want 0", PADDR, PWDATA, PWRITE); end
      @(posedge PCLK); #1; PRESET = 1'b0;
      @(negedge PCLK);
   endtask

   task automatic test_read_slot1();
      run_xfer(32'h1000_1004, 32'h0, 1'b0, 1, 32'h0000_00AB, 1'b0, 4'b0000);
      total++; if (obs_k !== 3) begin bad++; $display("FAIL read_latency got=%0d want=3", obs_k); end
      total++; if (obs_psel1 !== 4'b0010 || obs_pen1 !== 1'b0) begin bad++; $display("FAIL read_setup got PSEL=%b PEN=%b want 0010/0", obs_psel1, obs_pen1); end
      total++; if (obs_rdata !== 32'h0000_00AB || obs_err !== 1'b0) begin bad++; $display("FAIL read_data got %h err=%b want 000000ab err=0", obs_rdata, obs_err); end
      total++; if (obs_ready_after !== 1'b0 || obs_rdata_after !== 32'h0 || obs_psel_after !== 4'b0000) begin bad++; $display("FAIL read_after got rdy=%b rd=%h psel=%b want 0", obs_ready_after, obs_rdata_after, obs_psel_after); end
   endtask

   task automatic test_write();
      run_xfer(32'h1000_0008, 32'h0000_1234, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 4'b0000);
      total++; if (obs_k !== 2) begin bad++; $display("FAIL write_latency got=%0d want=2", obs_k); end
      total++; if (obs_pwrite !== 1'b1 || obs_pwdata !== 32'h0000_1234 || obs_paddr !== 32'h1000_0008) begin bad++; $display("FAIL write_req got %b %h %h want 1 00001234 10000008", obs_pwrite, obs_pwdata, obs_paddr); end
      total++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin bad++; $display("FAIL write_resp got rd=%h err=%b want 0/0", obs_rdata, obs_err); end
   endtask

   task automatic test_decode_miss();
      logic [31:0] miss_addr [2];
      miss_addr[0] = 32'h2000_0000;
      miss_addr[1] = 32'h1000_4000;
      for (int i = 0; i < 2; i++) begin
         run_xfer(miss_addr[i], 32'h0, 1'b0, 0, 32'h5555_5555, 1'b0, 4'b1111);
         total++; if (obs_k !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin bad++; $display("FAIL miss_resp[%0d] got k=%0d err=%b rd=%h want 1/1/0", i, obs_k, obs_err, obs_rdata); end
         total++; if (obs_psel1 !== 4'b0000 || obs_psel_after !== 4'b0000) begin bad++; $display("FAIL miss_psel[%0d] got %b/%b want 0000", i, obs_psel1, obs_psel_after); end
      end
   endtask

   task automatic test_timeout();
      run_xfer(32'h1000_3000, 32'h0, 1'b0, 99, 32'h7777_7777, 1'b0, 4'b0000);
      total++; if (obs_k !== 1 + TO || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin bad++; $display("FAIL timeout got k=%0d err=%b rd=%h want %0d/1/0", obs_k, obs_err, obs_rdata, 1 + TO); end
      total++; if (obs_psel_after !== 4'b0000 || obs_pen_after !== 1'b0 || obs_ready_after !== 1'b0) begin bad++; $display("FAIL timeout_idle got psel=%b pen=%b rdy=%b want 0", obs_psel_after, obs_pen_after, obs_ready_after); end
      run_xfer(32'h1000_3010, 32'h0, 1'b0, TO - 1, 32'h0BAD_F00D, 1'b0, 4'b0000);
      total++; if (obs_k !== 1 + TO || obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL timeout_last_ready got k=%0d err=%b rd=%h want %0d/0/0badf00d", obs_k, obs_err, obs_rdata, 1 + TO); end
   endtask

   task automatic test_other_pready();
      run_xfer(32'h1000_0010, 32'h0, 1'b0, 2, 32'h0000_C0DE, 1'b0, 4'b0100);
      total++; if (obs_k !== 4 || obs_err !== 1'b0 || obs_rdata !== 32'h0000_C0DE) begin bad++; $display("FAIL other_pready got k=%0d err=%b rd=%h want 4/0/0000c0de", obs_k, obs_err, obs_rdata); end
   endtask

   task automatic test_reset_mid();
      int spurious;
      transfer = 1'b1; addr = 32'h1000_2000; write = 1'b0; PREADY_s = 4'b0000;
      @(posedge PCLK); #1; transfer = 1'b0;
      @(posedge PCLK); #1;
      PREADY_s = 4'b0100; PRESET = 1'b1;
      #1;
      total++; if (PENABLE !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL midrst_cycle got pen=%b rdy=%b want 1/0", PENABLE, ready); end
      @(posedge PCLK); #1; PRESET = 1'b0; PREADY_s = 4'b0000;
      @(negedge PCLK);
      total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin bad++; $display("FAIL midrst_sel got %b/%b want 0000/0", PSEL, PENABLE); end
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge PCLK);
         if (ready !== 1'b0) spurious++;
      end
      total++; if (spurious !== 0) begin bad++; $display("FAIL midrst_noready got=%0d want=0", spurious); end
      run_xfer(32'h1000_2000, 32'h0, 1'b0, 1, 32'h1111_2222, 1'b0, 4'b0000);
      total++; if (obs_k !== 3 || obs_rdata !== 32'h1111_2222) begin bad++; $display("FAIL midrst_after got k=%0d rd=%h want 3/11112222", obs_k, obs_rdata); end
   endtask

   task automatic test_back_to_back();
      run_xfer(32'h1000_1000, 32'h0000_00A1, 1'b1, 1, 32'h0, 1'b1, 4'b0000);
      total++; if (obs_k !== 3 || obs_psel_after !== 4'b0000) begin bad++; $display("FAIL b2b_first got k=%0d psel_after=%b want 3/0000", obs_k, obs_psel_after); end
      run_xfer(32'h1000_3004, 32'h0, 1'b0, 0, 32'h0000_0B2B, 1'b0, 4'b0000);
      total++; if (obs_k !== 2 || obs_rdata !== 32'h0000_0B2B || obs_psel1 !== 4'b1000) begin bad++; $display("FAIL b2b_second got k=%0d rd=%h psel=%b want 2/00000b2b/1000", obs_k, obs_rdata, obs_psel1); end
   endtask

   task automatic test_random();
      logic [31:0] a, wd, sd;
      logic        wr, keep;
      int          w;
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 9) < 8) a = BASE + (32'($urandom_range(0, NS - 1)) << 12) + (32'($urandom_range(0, 1023)) << 2);
         else a = $urandom;
         wd = $urandom; sd = $urandom; wr = 1'($urandom); keep = 1'($urandom);
         w = $urandom_range(0, 5);
         model(a, wr, w, sd);
         run_xfer(a, wd, wr, w, sd, keep, 4'b0000);
         total++; if (obs_k !== ek) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, obs_k, ek); end
         total++; if (obs_err !== eerr || obs_rdata !== erd) begin bad++; $display("FAIL rnd%0d_resp got err=%b rd=%h want %b/%h", n, obs_err, obs_rdata, eerr, erd); end
         total++; if (obs_paddr !== a || obs_pwdata !== wd || obs_pwrite !== wr) begin bad++; $display("FAIL rnd%0d_req got %h %h %b want %h %h %b", n, obs_paddr, obs_pwdata, obs_pwrite, a, wd, wr); end
         total++; if (obs_psel1 !== epsel || obs_pen1 !== 1'b0 || obs_pselc !== epsel || obs_penc !== (epsel != 4'b0000)) begin bad++; $display("FAIL rnd%0d_sel got %b/%b %b/%b want %b", n, obs_psel1, obs_pen1, obs_pselc, obs_penc, epsel); end
         total++; if (obs_psel_after !== 4'b0000 || obs_ready_after !== 1'b0 || obs_err_after !== 1'b0) begin bad++; $display("FAIL rnd%0d_after got psel=%b rdy=%b err=%b want 0", n, obs_psel_after, obs_ready_after, obs_err_after); end
      end
   endtask

   initial begin
      test_reset();
      test_read_slot1();
      test_write();
      test_decode_miss();
      test_timeout();
      test_other_pready();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
